// File: rtl/systolic_feeder.sv
// systolic_feeder: loads 3x3 operand matrices A (by row) and B (by column),
// then streams them skewed and zero-padded into a 3x3 systolic MAC array.
// Optional build macro: SYSTOLIC_FEEDER_REPLAY_EN keeps operands after a run
// so another start replays the same matrices without reloading.
module systolic_feeder #(
  parameter int DW    = 8,
  parameter int FLUSH = 4
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [3*DW-1:0] ld_a,
  input  logic [3*DW-1:0] ld_b,
  input  logic            start,
  output logic            mac_clr,
  output logic [3*DW-1:0] a_out,
  output logic [3*DW-1:0] b_out,
  output logic            busy,
  output logic            done
);

  localparam int FW = (FLUSH > 1) ? $clog2(FLUSH) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOADED, S_CLEAR, S_STREAM, S_FLUSH, S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [1:0]      r_beat;
  logic [2:0]      r_step;
  logic [2:0]      w_nstep;
  logic [FW-1:0]   r_fcnt;
  logic [DW-1:0]   r_a [3][3];
  logic [DW-1:0]   r_b [3][3];
  logic            w_take;
  logic [1:0]      w_idx;
  logic            w_ready_d;
  logic            w_clr_d;
  logic            w_busy_d;
  logic            w_done_d;
  logic [3*DW-1:0] w_a_d;
  logic [3*DW-1:0] w_b_d;
  logic [2:0]      w_diff;
  logic [1:0]      w_k;

  // A load beat transfers only while the registered ready is high.
  assign w_take = ld_valid & ld_ready;
  // In LOADED (replay build) a beat restarts the load at row/column 0.
  assign w_idx  = (r_state == S_LOADED) ? 2'd0 : r_beat;

  // State, stream step and flush counter registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
      r_step  <= '0;
      r_fcnt  <= '0;
    end else begin
      r_state <= w_next;
      r_step  <= w_nstep;
      r_fcnt  <= (r_state == S_FLUSH) ? r_fcnt + 1'b1 : '0;
    end
  end

  // Next-state and next stream step selection.
  always_comb begin
    w_next  = r_state;
    w_nstep = '0;
    case (r_state)
      S_IDLE:   if (w_take && r_beat == 2'd2) w_next = S_LOADED;
`ifdef SYSTOLIC_FEEDER_REPLAY_EN
      S_LOADED: if (w_take) w_next = S_IDLE;
                else if (start) w_next = S_CLEAR;
`else
      S_LOADED: if (start) w_next = S_CLEAR;
`endif
      S_CLEAR:  w_next = S_STREAM;
      S_STREAM: begin
        if (r_step == 3'd4) w_next = (FLUSH == 0) ? S_DONE : S_FLUSH;
        else                w_nstep = r_step + 3'd1;
      end
      S_FLUSH:  if (r_fcnt == FW'(FLUSH - 1)) w_next = S_DONE;
`ifdef SYSTOLIC_FEEDER_REPLAY_EN
      S_DONE:   w_next = S_LOADED;
`else
      S_DONE:   w_next = S_IDLE;
`endif
      default:  w_next = S_IDLE;
    endcase
  end

  // Next values of every registered output, derived from the next state.
  always_comb begin
    w_ready_d = (w_next == S_IDLE);
`ifdef SYSTOLIC_FEEDER_REPLAY_EN
    w_ready_d = w_ready_d || (w_next == S_LOADED);
`endif
    w_clr_d  = (w_next == S_CLEAR);
    w_busy_d = (w_next == S_CLEAR) || (w_next == S_STREAM) || (w_next == S_FLUSH);
    w_done_d = (w_next == S_DONE);
    w_a_d    = '0;
    w_b_d    = '0;
    w_diff   = '0;
    w_k      = '0;
    if (w_next == S_STREAM) begin
      for (int i = 0; i < 3; i++) begin
        w_diff = w_nstep - 3'(i);
        if (w_nstep >= 3'(i) && w_diff <= 3'd2) begin
          w_k = w_diff[1:0];
          w_a_d[i*DW +: DW] = r_a[i[1:0]][w_k];
          w_b_d[i*DW +: DW] = r_b[w_k][i[1:0]];
        end
      end
    end
  end

  // Output registers; ready is the only output that is high out of reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ld_ready <= 1'b1;
      mac_clr  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      a_out    <= '0;
      b_out    <= '0;
    end else begin
      ld_ready <= w_ready_d;
      mac_clr  <= w_clr_d;
      busy     <= w_busy_d;
      done     <= w_done_d;
      a_out    <= w_a_d;
      b_out    <= w_b_d;
    end
  end

  // Operand storage and beat counter; cleared after a run unless replaying.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_beat <= '0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          r_a[r][c] <= '0;
          r_b[r][c] <= '0;
        end
      end
    end else if (w_take) begin
      for (int c = 0; c < 3; c++) begin
        r_a[w_idx][c[1:0]] <= ld_a[c*DW +: DW];
        r_b[c[1:0]][w_idx] <= ld_b[c*DW +: DW];
      end
      if (r_state == S_LOADED) r_beat <= 2'd1;
      else                     r_beat <= (r_beat == 2'd2) ? 2'd0 : r_beat + 2'd1;
`ifndef SYSTOLIC_FEEDER_REPLAY_EN
    end else if (r_state == S_DONE) begin
      r_beat <= '0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          r_a[r][c] <= '0;
          r_b[r][c] <= '0;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Testbench for systolic_feeder: scoreboard of per-cycle expected outputs,
// pushed when a run is started and popped on every falling clock edge.
module tb_systolic_feeder;

  localparam int DW    = 8;
  localparam int FLUSH = 4;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          ld_valid = 1'b0;
  logic          start = 1'b0;
  logic [23:0]   ld_a = '0;
  logic [23:0]   ld_b = '0;
  logic          ld_ready;
  logic          mac_clr;
  logic          busy;
  logic          done;
  logic [23:0]   a_out;
  logic [23:0]   b_out;

  logic [7:0]    ma [3][3];
  logic [7:0]    mb [3][3];
  logic [63:0]   sbq [$];
  logic [63:0]   monExp;
  int            seqIdx = 0;
  int            nTests = 0;
  int            nFail = 0;
  logic          expLoaded;

  systolic_feeder #(.DW(DW), .FLUSH(FLUSH)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_a(ld_a), .ld_b(ld_b),
    .start(start), .mac_clr(mac_clr), .a_out(a_out), .b_out(b_out),
    .busy(busy), .done(done)
  );

  always #5 CLK = ~CLK;

  // Single comparison point: counts and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nTests++;
    if (obs !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pack(input logic ldr, input logic clr, input logic bsy,
                                       input logic dn, input logic [23:0] a, input logic [23:0] b);
    return {12'd0, ldr, clr, bsy, dn, a, b};
  endfunction

  // Expected west lanes at stream step t: lane i carries A[i][t-i].
  function automatic logic [23:0] laneA(input int t);
    logic [23:0] v = '0;
    for (int i = 0; i < 3; i++)
      if (t - i >= 0 && t - i <= 2) v[i*8 +: 8] = ma[i][t-i];
    return v;
  endfunction

  // Expected north lanes at stream step t: lane j carries B[t-j][j].
  function automatic logic [23:0] laneB(input int t);
    logic [23:0] v = '0;
    for (int j = 0; j < 3; j++)
      if (t - j >= 0 && t - j <= 2) v[j*8 +: 8] = mb[t-j][j];
    return v;
  endfunction

  // Compare every cycle while the scoreboard holds expectations.
  always @(negedge CLK) begin
    if (sbq.size() > 0) begin
      monExp = sbq.pop_front();
      checkOutput($sformatf("seq%0d", seqIdx),
                  pack(ld_ready, mac_clr, busy, done, a_out, b_out), monExp);
      seqIdx++;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic pushIdle(input int n, input logic ldr);
    repeat (n) sbq.push_back(pack(ldr, 1'b0, 1'b0, 1'b0, 24'd0, 24'd0));
  endtask

  task automatic pushRun();
    sbq.push_back(pack(1'b0, 1'b1, 1'b1, 1'b0, 24'd0, 24'd0));
    for (int t = 0; t < 5; t++) sbq.push_back(pack(1'b0, 1'b0, 1'b1, 1'b0, laneA(t), laneB(t)));
    repeat (FLUSH) sbq.push_back(pack(1'b0, 1'b0, 1'b1, 1'b0, 24'd0, 24'd0));
    sbq.push_back(pack(1'b0, 1'b0, 1'b0, 1'b1, 24'd0, 24'd0));
    sbq.push_back(pack(1'b1, 1'b0, 1'b0, 1'b0, 24'd0, 24'd0));
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 200 && sbq.size() > 0; i++) @(posedge CLK);
    #1;
    if (sbq.size() > 0) begin
      checkOutput("drain timeout", 64'(sbq.size()), 64'd0);
      sbq.delete();
    end
  endtask

  task automatic beat(input int k, input logic withStart);
    checkOutput($sformatf("ld_ready before beat %0d", k), 64'(ld_ready), 64'd1);
    ld_valid = 1'b1;
    start    = withStart;
    ld_a     = {ma[k][2], ma[k][1], ma[k][0]};
    ld_b     = {mb[2][k], mb[1][k], mb[0][k]};
    @(posedge CLK); #1;
    ld_valid = 1'b0;
    start    = 1'b0;
    ld_a     = 24'($urandom);
    ld_b     = 24'($urandom);
  endtask

  // Load three beats with idle gaps; first beat optionally carries start.
  task automatic applyStimulus(input int g0, input int g1, input logic startOnFirst);
    beat(0, startOnFirst);
    idle(g0);
    beat(1, 1'b0);
    idle(g1);
    beat(2, 1'b0);
    checkOutput("ld_ready after load", 64'(ld_ready), 64'(expLoaded));
  endtask

  task automatic startRun(input logic doPush);
    start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    if (doPush) pushRun();
  endtask

  task automatic setCommon();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        ma[r][c] = 8'(1 + 3*r + c);
        mb[r][c] = 8'(10 + 3*c + r);
      end
  endtask

  task automatic setConst();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        ma[r][c] = 8'h30;
        mb[r][c] = 8'hB8;
      end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
`ifdef SYSTOLIC_FEEDER_REPLAY_EN
    expLoaded = 1'b1;
`else
    expLoaded = 1'b0;
`endif
    setCommon();

    // Reset state
    #3;
    checkOutput("reset outputs", pack(1'b0, mac_clr, busy, done, a_out, b_out), 64'd0);
    #9 RST_N = 1'b1;
    @(posedge CLK); #1;
    checkOutput("out of reset", pack(ld_ready, mac_clr, busy, done, a_out, b_out),
                pack(1'b1, 1'b0, 1'b0, 1'b0, 24'd0, 24'd0));

    // Start in IDLE is ignored, then gapped load with start on the first beat
    startRun(1'b0);
    pushIdle(3, 1'b1);
    waitDrain();
    applyStimulus(2, 3, 1'b1);
    pushIdle(2, expLoaded);
    waitDrain();
    startRun(1'b1);
    waitDrain();

    // Start during STREAM and ld_valid during FLUSH are both ignored
    applyStimulus(0, 0, 1'b0);
    startRun(1'b1);
    idle(2);
    start = 1'b1;
    idle(2);
    start = 1'b0;
    idle(3);
    ld_valid = 1'b1;
    ld_a = 24'hFFFFFF;
    ld_b = 24'hFFFFFF;
    idle(1);
    ld_valid = 1'b0;
    waitDrain();

`ifdef SYSTOLIC_FEEDER_REPLAY_EN
    // Replay: a second start without reload repeats the streams
    startRun(1'b1);
    waitDrain();
`else
    // No replay: start ignored until three fresh beats are loaded
    startRun(1'b0);
    pushIdle(4, 1'b1);
    waitDrain();
    beat(0, 1'b0);
    beat(1, 1'b0);
    startRun(1'b0);
    pushIdle(3, 1'b1);
    waitDrain();
    beat(2, 1'b0);
    checkOutput("ld_ready after reload", 64'(ld_ready), 64'd0);
    startRun(1'b1);
    waitDrain();
`endif

    // Reset at stream step 2, then a fresh constant load and run
    applyStimulus(0, 0, 1'b0);
    startRun(1'b0);
    idle(2);
    @(posedge CLK); #2;
    checkOutput("step2 a_out", 64'(a_out), 64'(laneA(2)));
    checkOutput("step2 b_out", 64'(b_out), 64'(laneB(2)));
    RST_N = 1'b0;
    #1;
    checkOutput("async reset", pack(1'b0, mac_clr, busy, done, a_out, b_out), 64'd0);
    @(posedge CLK); #3;
    RST_N = 1'b1;
    @(posedge CLK); #1;
    checkOutput("idle after reset", pack(ld_ready, mac_clr, busy, done, a_out, b_out),
                pack(1'b1, 1'b0, 1'b0, 1'b0, 24'd0, 24'd0));
    setConst();
    applyStimulus(0, 0, 1'b0);
    startRun(1'b1);
    waitDrain();

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/systolic_feeder.md
# systolic_feeder

Operand feeder for the 3x3 systolic matrix multiplier. Accepts matrix A row by row and matrix B column by column over a valid/ready load port and stores both. On `start` it pulses an accumulator clear, then drives the skewed, zero-padded operand streams into the west edge (A) and north edge (B) of the MAC array. It then flushes zeros and signals `done`.

## Interface
- `DW`, default 8: operand element width.
- `FLUSH`, default 4: zero cycles after the last stream step before `done`.

- `CLK` in 1: clock, rising edge.
- `RST_N` in 1: reset, asynchronous, active-low.
- `ld_valid` in 1: load beat valid.
- `ld_ready` out 1: feeder can accept a load beat.
- `ld_a` in 3*DW: on beat k, A[k][c] at bits [c*DW +: DW].
- `ld_b` in 3*DW: on beat k, B[r][k] at bits [r*DW +: DW].
- `start` in 1: begin a run (sampled in LOADED only).
- `mac_clr` out 1: one-cycle clear to MAC accumulators.
- `a_out` out 3*DW: lane i (array row i) at [i*DW +: DW].
- `b_out` out 3*DW: lane j (array column j) at [j*DW +: DW].
- `busy` out 1: high in CLEAR, STREAM and FLUSH.
- `done` out 1: one-cycle pulse at end of run.

## Operation
- State machine: IDLE → LOADED → CLEAR → STREAM → FLUSH → DONE → IDLE.
- IDLE:
  - `ld_ready`=1.
  - Beat counter 0..2; each `ld_valid` beat stores row/column k and increments the counter.
  - The third beat moves to LOADED.
  - `start` is ignored.
- LOADED:
  - `ld_ready`=0.
  - `start`=1 moves to CLEAR.
- CLEAR: one cycle, `mac_clr`=1, streams zero.
- STREAM: steps t=0..4.
  - Lane i of `a_out` carries A[i][t-i] if 0≤t-i≤2, else 0.
  - Lane j of `b_out` carries B[t-j][j] if 0≤t-j≤2, else 0.
- FLUSH: FLUSH cycles with streams zero.
- DONE: one cycle, `done`=1, then IDLE with the beat counter at 0.
- All outputs are registered. Values are unsigned and passed through unmodified; there is no arithmetic on data.
- `start` is ignored outside LOADED. `ld_valid` is ignored whenever `ld_ready`=0.
- `start` and `ld_valid` in the same IDLE cycle: the load beat is taken and `start` is ignored.
- Reset, including mid-run, forces IDLE immediately and clears the beat counter and all operand storage. All outputs go to 0 (`ld_ready`=1 once out of reset).

## Timing
- Reset values:
  - `ld_ready`=1.
  - `mac_clr`=0, `busy`=0, `done`=0.
  - `a_out`=0, `b_out`=0.
- Load: a beat transfers on a rising edge with `ld_valid`=`ld_ready`=1. Three beats are needed; `ld_ready` drops the cycle after the third beat.
- Start at edge k (in LOADED):
  - Cycle k+1: `mac_clr`=1, `busy`=1.
  - Cycles k+2..k+6: STREAM steps 0..4.
  - Cycles k+7..k+6+FLUSH: zeros.
  - Cycle k+7+FLUSH: `done`=1, `busy`=0.
  - Cycle k+8+FLUSH: `ld_ready`=1.
- Throughput: one run per 3 + 1 + 5 + FLUSH + 1 cycles, plus the start wait.

## Configuration
- `SYSTOLIC_FEEDER_REPLAY_EN` defined:
  - DONE returns to LOADED with operands retained, so another `start` reruns the same matrices.
  - In LOADED `ld_ready`=1. A load beat there overwrites row/column 0, sets the beat counter to 1 and moves to IDLE.
- Not defined: DONE returns to IDLE and stored operands are cleared.

## Test plan
Common stimulus: A rows {1,2,3},{4,5,6},{7,8,9}; B columns {10,11,12},{13,14,15},{16,17,18}.

- Load plus `start`, FLUSH=4:
  - `mac_clr` high exactly one cycle.
  - `a_out` lanes per step: (1,0,0), (2,4,0), (3,5,7), (0,6,8), (0,0,9).
  - `b_out` lanes per step: (10,0,0), (11,13,0), (12,14,16), (0,15,17), (0,0,18).
  - Then 4 zero cycles and a one-cycle `done`.
- Gapped `ld_valid` (beats on cycles 0, 3, 7): same stored data; `ld_ready` low after the third beat; `start` pulsed in IDLE beforehand has no effect.
- `start` asserted during STREAM and `ld_valid` during FLUSH: both ignored; stream sequence and `done` timing unchanged.
- `RST_N` low at STREAM step 2:
  - All outputs 0 asynchronously and state IDLE.
  - A fresh load of all 0x30 / all 0xB8 then streams lane values 0x30 and 0xB8 at the correct skews.
- Macro on: after `done`, a second `start` without reload repeats the identical streams. Macro off: after `done`, `ld_ready`=1 and `start` is ignored until three beats are loaded.
